// File: rtl/stream_line_capture_pkg.sv
// Shared constants and types for the line-capture sink and its pixel_generator counterpart.
package stream_line_capture_pkg;

  localparam int unsigned X_SIZE    = 1280;
  localparam int unsigned Y_SIZE    = 720;
  localparam logic [7:0]  THRESHOLD = 8'h80;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned KEEP_W = 4;
  localparam int unsigned PX_W   = 11;
  localparam int unsigned ROW_W  = 10;
  localparam int unsigned HOLD_W = 16;
  localparam int unsigned ERR_W  = 3;

  // Packing phases: three 32-bit words carry four 24-bit pixels.
  localparam logic [1:0] PH0 = 2'd0;
  localparam logic [1:0] PH1 = 2'd1;
  localparam logic [1:0] PH2 = 2'd2;

  localparam int unsigned ERR_SHORT_LINE    = 0;
  localparam int unsigned ERR_LONG_LINE     = 1;
  localparam int unsigned ERR_SOF_MID_FRAME = 2;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    RUN      = 2'd1,
    DRAIN    = 2'd2,
    WRITE    = 2'd3
  } state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  function automatic logic pixel_alive(input pixel_t p, input logic [7:0] thr);
    return (p.r >= thr);
  endfunction

endpackage

// File: rtl/stream_line_capture_unpacker.sv
// Combinational 24-bpp unpacker: one packed word plus the carried bytes yields one or two pixels.
module rgb24_unpacker
  import stream_line_capture_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  input  logic [1:0]        ph_i,
  input  logic [HOLD_W-1:0] held_i,
  output pixel_t            pix0_o,
  output pixel_t            pix1_o,
  output logic [1:0]        cnt_o,
  output logic [HOLD_W-1:0] held_o
);

  always_comb begin
    pix0_o = word_i[23:0];
    pix1_o = '0;
    cnt_o  = 2'd1;
    held_o = {8'h00, word_i[31:24]};
    case (ph_i)
      PH1: begin
        pix0_o = {word_i[15:0], held_i[7:0]};
        held_o = word_i[31:16];
      end
      PH2: begin
        pix0_o = {word_i[7:0], held_i};
        pix1_o = word_i[31:8];
        cnt_o  = 2'd2;
        held_o = held_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/stream_line_capture.sv
// AXI4-Stream video sink: unpacks 24-bpp words, thresholds red, and writes one bit-row per line.
module stream_line_capture
  import stream_line_capture_pkg::*;
#(
  parameter int unsigned X_SIZE    = stream_line_capture_pkg::X_SIZE,
  parameter int unsigned Y_SIZE    = stream_line_capture_pkg::Y_SIZE,
  parameter logic [7:0]  THRESHOLD = stream_line_capture_pkg::THRESHOLD
) (
  input  logic              in_stream_aclk,
  input  logic              periph_reset,
  input  logic              capture_en,
  input  logic [WORD_W-1:0] in_stream_tdata,
  input  logic [KEEP_W-1:0] in_stream_tkeep,
  input  logic              in_stream_tlast,
  input  logic              in_stream_tuser,
  input  logic              in_stream_tvalid,
  output logic              in_stream_tready,
  output logic [ROW_W-1:0]  line_addr,
  output logic [X_SIZE-1:0] line_data,
  output logic              line_we,
  output logic              frame_done,
  output logic [ERR_W-1:0]  err_flags
);

  localparam int unsigned IDX_W = $clog2(X_SIZE);

  state_e             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [PX_W-1:0]    px_q, px_d;
  logic [1:0]         ph_q, ph_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [X_SIZE-1:0]  line_q, line_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               frame_done_q, frame_done_d;
  logic               line_we_q, line_we_d;

  logic               accept_c, restart_c, unpack_c;
  logic [PX_W-1:0]    px_base_c;
  logic [1:0]         ph_base_c;
  pixel_t             pix0_c, pix1_c;
  logic [1:0]         cnt_c;
  logic [HOLD_W-1:0]  held_nxt_c;
  logic               unused_tkeep;

  assign unused_tkeep = ^in_stream_tkeep;

  assign in_stream_tready = capture_en & (state_q != WRITE);
  assign accept_c  = in_stream_tvalid & in_stream_tready;
  // Any accepted SOF word restarts the frame and is unpacked as word 0 of row 0.
  assign restart_c = accept_c & in_stream_tuser;
  assign unpack_c  = accept_c & (in_stream_tuser | (state_q == RUN));
  assign px_base_c = restart_c ? '0 : px_q;
  assign ph_base_c = restart_c ? PH0 : ph_q;

  rgb24_unpacker u_unpacker (
    .word_i (in_stream_tdata),
    .ph_i   (ph_base_c),
    .held_i (hold_q),
    .pix0_o (pix0_c),
    .pix1_o (pix1_c),
    .cnt_o  (cnt_c),
    .held_o (held_nxt_c)
  );

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    px_d         = px_q;
    ph_d         = ph_q;
    hold_d       = hold_q;
    line_d       = line_q;
    err_d        = err_q;
    frame_done_d = 1'b0;

    case (state_q)
      DRAIN: begin
        if (accept_c && !in_stream_tuser && in_stream_tlast) state_d = WRITE;
      end
      WRITE: begin
        line_d = '0;
        px_d   = '0;
        ph_d   = PH0;
        if (row_q == ROW_W'(Y_SIZE - 1)) begin
          frame_done_d = 1'b1;
          state_d      = WAIT_SOF;
        end else begin
          row_d   = row_q + ROW_W'(1);
          state_d = RUN;
        end
      end
      default: ;
    endcase

    if (restart_c) begin
      row_d  = '0;
      line_d = '0;
      if (state_q != WAIT_SOF) err_d[ERR_SOF_MID_FRAME] = 1'b1;
    end

    if (unpack_c) begin
      line_d[IDX_W'(X_SIZE - 1 - 32'(px_base_c))] = pixel_alive(pix0_c, THRESHOLD);
      if (cnt_c == 2'd2) line_d[IDX_W'(X_SIZE - 2 - 32'(px_base_c))] = pixel_alive(pix1_c, THRESHOLD);
      px_d   = px_base_c + PX_W'(cnt_c);
      ph_d   = (ph_base_c == PH2) ? PH0 : ph_base_c + 2'd1;
      hold_d = held_nxt_c;
      if (in_stream_tlast) begin
        state_d = WRITE;
        if (px_d < PX_W'(X_SIZE)) err_d[ERR_SHORT_LINE] = 1'b1;
      end else if (px_d == PX_W'(X_SIZE)) begin
        state_d = DRAIN;
        err_d[ERR_LONG_LINE] = 1'b1;
      end else begin
        state_d = RUN;
      end
    end

    line_we_d = (state_d == WRITE);
  end

  always_ff @(posedge in_stream_aclk or posedge periph_reset) begin
    if (periph_reset) begin
      state_q      <= WAIT_SOF;
      row_q        <= '0;
      px_q         <= '0;
      ph_q         <= PH0;
      hold_q       <= '0;
      line_q       <= '0;
      err_q        <= '0;
      frame_done_q <= 1'b0;
      line_we_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      px_q         <= px_d;
      ph_q         <= ph_d;
      hold_q       <= hold_d;
      line_q       <= line_d;
      err_q        <= err_d;
      frame_done_q <= frame_done_d;
      line_we_q    <= line_we_d;
    end
  end

  assign line_addr  = row_q;
  assign line_data  = line_q;
  assign line_we    = line_we_q;
  assign frame_done = frame_done_q;
  assign err_flags  = err_q;

endmodule

// File: tb/tb_stream_line_capture.sv
// Bench for stream_line_capture on a reduced 32x6 frame against a byte-stream reference model.
module tb_stream_line_capture;

  localparam int X = 32;
  localparam int Y = 6;
  localparam int W = (X * 3) / 4;
  localparam logic [7:0] THR = 8'h80;

  typedef logic [31:0] wq_t[$];

  logic          clk = 1'b0;
  logic          periph_reset;
  logic          capture_en;
  logic [31:0]   tdata;
  logic [3:0]    tkeep;
  logic          tlast, tuser, tvalid, tready;
  logic [9:0]    line_addr;
  logic [X-1:0]  line_data;
  logic          line_we, frame_done;
  logic [2:0]    err_flags;

  stream_line_capture #(.X_SIZE(X), .Y_SIZE(Y), .THRESHOLD(THR)) dut (
    .in_stream_aclk   (clk),
    .periph_reset     (periph_reset),
    .capture_en       (capture_en),
    .in_stream_tdata  (tdata),
    .in_stream_tkeep  (tkeep),
    .in_stream_tlast  (tlast),
    .in_stream_tuser  (tuser),
    .in_stream_tvalid (tvalid),
    .in_stream_tready (tready),
    .line_addr        (line_addr),
    .line_data        (line_data),
    .line_we          (line_we),
    .frame_done       (frame_done),
    .err_flags        (err_flags)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [9:0]   exp_addr[$];
  logic [X-1:0] exp_data[$];
  logic [X-1:0] cap[Y];
  int           row_m = 0;
  int           frames_exp = 0;
  int           frames_seen = 0;
  logic [2:0]   err_m = '0;
  bit           gaps = 0;
  logic         prev_we = 1'b0;
  logic [9:0]   prev_addr = '0;
  logic [9:0]   m_addr;
  logic [X-1:0] m_data;
  wq_t          f1[Y];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bytes stream little-endian; pixel k is bytes 3k..3k+2 with red in the top byte.
  function automatic logic [X-1:0] model_line(input wq_t w);
    logic [X-1:0] r;
    logic [31:0]  wd;
    logic [7:0]   red;
    int n, np, b;
    r  = '0;
    n  = (w.size() > W) ? W : w.size();
    np = (4 * n) / 3;
    for (int k = 0; k < np; k++) begin
      b   = 3 * k + 2;
      wd  = w[b / 4];
      red = wd[8 * (b % 4) +: 8];
      r[X - 1 - k] = (red >= THR);
    end
    return r;
  endfunction

  function automatic wq_t rand_row(input int n);
    wq_t q;
    for (int i = 0; i < n; i++) q.push_back($urandom);
    return q;
  endfunction

  always @(negedge clk) begin
    if (!capture_en) chk("tready_en_low", 64'(tready), 64'd0);
    if (line_we) begin
      chk("tready_in_write", 64'(tready), 64'd0);
      chk("we_expected", (exp_addr.size() > 0) ? 64'd1 : 64'd0, 64'd1);
      if (exp_addr.size() > 0) begin
        m_addr = exp_addr.pop_front();
        m_data = exp_data.pop_front();
        chk("line_addr", 64'(line_addr), 64'(m_addr));
        chk("line_data", 64'(line_data), 64'(m_data));
        if (line_addr < 10'(Y)) cap[line_addr] = line_data;
      end
    end
    if (frame_done) begin
      frames_seen++;
      chk("frame_done_after_last", {53'd0, prev_we, prev_addr}, {53'd0, 1'b1, 10'(Y - 1)});
    end
    prev_we   = line_we;
    prev_addr = line_addr;
  end

  task automatic send(input logic [31:0] d, input logic u, input logic l);
    int guard = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        #1;
        capture_en = 1'b0;
        tdata = d; tuser = u; tlast = l; tvalid = 1'b1;
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          #1;
          chk("tready_stall", 64'(tready), 64'd0);
        end
        capture_en = 1'b1;
      end
    end
    tdata = d; tuser = u; tlast = l; tvalid = 1'b1;
    #1;
    while (!tready) begin
      @(negedge clk);
      #1;
      guard++;
      if (guard > 50) begin
        checks++;
        errors++;
        $error("FAIL tready_timeout observed=0 expected=1");
        break;
      end
    end
    @(negedge clk);
    tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
  endtask

  // sof_at < 0: no tuser in this row; with_last = 0: row is abandoned without tlast.
  task automatic send_row(input wq_t w, input int sof_at, input bit with_last);
    wq_t eff;
    if (with_last) begin
      for (int j = (sof_at > 0 ? sof_at : 0); j < w.size(); j++) eff.push_back(w[j]);
      if (sof_at >= 0) row_m = 0;
      if (sof_at > 0) err_m[2] = 1'b1;
      if (eff.size() < W) err_m[0] = 1'b1;
      if (eff.size() > W) err_m[1] = 1'b1;
      exp_addr.push_back(10'(row_m));
      exp_data.push_back(model_line(eff));
    end
    for (int i = 0; i < w.size(); i++)
      send(w[i], logic'(i == sof_at), logic'(with_last && (i == w.size() - 1)));
    if (with_last) begin
      chk("we_latency", 64'(line_we), 64'd1);
      if (row_m == Y - 1) begin
        frames_exp++;
        row_m = 0;
      end else begin
        row_m++;
      end
    end
  endtask

  initial begin
    wq_t w;
    logic [31:0] t;
    logic [3:0]  top4;
    periph_reset = 1'b1;
    capture_en = 1'b1;
    tdata = '0; tkeep = 4'hF; tlast = 1'b0; tuser = 1'b0; tvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_line_we", 64'(line_we), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_err", 64'(err_flags), 64'd0);
    chk("rst_addr", 64'(line_addr), 64'd0);
    chk("rst_data", 64'(line_data), 64'd0);
    chk("rst_tready", 64'(tready), 64'd1);
    periph_reset = 1'b0;
    @(negedge clk);
    #1 capture_en = 1'b0;
    @(negedge clk);
    chk("tready_cap_off", 64'(tready), 64'd0);
    #1 capture_en = 1'b1;

    // Words before any SOF are dropped.
    repeat (4) send($urandom, 1'b0, logic'($urandom_range(0, 1)));
    chk("discard_err", 64'(err_flags), 64'd0);

    // Frame 1: clean, with threshold boundary values at pixels 0..3.
    for (int r = 0; r < Y; r++) begin
      w = rand_row(W);
      if (r == 0) begin
        t = w[0]; t[23:16] = 8'h80; w[0] = t;
        t = w[1]; t[15:8]  = 8'h7F; w[1] = t;
        t = w[2]; t[7:0]   = 8'h80; t[31:24] = 8'h7F; w[2] = t;
      end
      f1[r] = w;
      send_row(w, (r == 0) ? 0 : -1, 1'b1);
    end
    repeat (3) @(negedge clk);
    top4 = cap[0][X-1 -: 4];
    chk("threshold_bits", 64'(top4), 64'hA);
    chk("f1_err", 64'(err_flags), 64'd0);
    chk("f1_frames", 64'(frames_seen), 64'(frames_exp));

    // Frame 2: short, long, then SOF mid-row restarting the frame.
    send_row(rand_row(W), 0, 1'b1);
    send_row(rand_row(10), -1, 1'b1);
    chk("err_short", 64'(err_flags), 64'(err_m));
    send_row(rand_row(W + 4), -1, 1'b1);
    chk("err_long", 64'(err_flags), 64'(err_m));
    send_row(rand_row(W + 5), 5, 1'b1);
    chk("err_sof_mid", 64'(err_flags), 64'd7);
    for (int r = 1; r < Y; r++) send_row(rand_row(W), -1, 1'b1);
    repeat (3) @(negedge clk);
    chk("f2_frames", 64'(frames_seen), 64'(frames_exp));

    // Reset mid-frame drops the partial row and clears the sticky flags.
    send_row(rand_row(10), 0, 1'b0);
    periph_reset = 1'b1;
    @(negedge clk);
    chk("midrst_we", 64'(line_we), 64'd0);
    chk("midrst_err", 64'(err_flags), 64'd0);
    periph_reset = 1'b0;
    err_m = '0;
    row_m = 0;
    @(negedge clk);

    // Frame 3: frame-1 data with random gaps and capture_en stalls.
    gaps = 1;
    for (int r = 0; r < Y; r++) send_row(f1[r], (r == 0) ? 0 : -1, 1'b1);
    gaps = 0;
    repeat (3) @(negedge clk);
    chk("f3_err", 64'(err_flags), 64'd0);

    // Frame 4: one-word row carrying both SOF and EOL.
    send_row(rand_row(1), 0, 1'b1);
    chk("err_one_word", 64'(err_flags), 64'd1);
    for (int r = 1; r < Y; r++) send_row(rand_row(W), -1, 1'b1);

    repeat (5) @(negedge clk);
    chk("pending_writes", 64'(exp_addr.size()), 64'd0);
    chk("frames_total", 64'(frames_seen), 64'(frames_exp));
    chk("final_err", 64'(err_flags), 64'(err_m));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
